// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for a 5-stage pipeline: shadow EX/MEM/WB destination records,
// EX operand bypass selection, load-use / RAW stall detection and stall performance counters.
module fwd_hazard_unit #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned FWD_EN   = 1,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       id_valid,
   input  logic [NUM_RD*REG_AW-1:0]   id_rs,
   input  logic [NUM_RD-1:0]          id_rs_used,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic                       id_we,
   input  logic                       id_load,
   input  logic [NUM_RD*DATA_W-1:0]   ex_rf_data,
   input  logic [DATA_W-1:0]          exmem_alu,
   input  logic [DATA_W-1:0]          memwb_wdata,
   output logic [NUM_RD*DATA_W-1:0]   ex_opnd,
   output logic [NUM_RD*2-1:0]        fwd_sel,
   output logic                       stall,
   output logic                       bubble,
   output logic [CNT_W-1:0]           stall_cycles,
   output logic [CNT_W-1:0]           stall_events
);

   localparam logic [0:0] StRun   = 1'b0;
   localparam logic [0:0] StStall = 1'b1;

   typedef struct packed {
      logic                     valid;
      logic [REG_AW-1:0]        rd;
      logic                     we;
      logic                     load;
      logic [NUM_RD*REG_AW-1:0] rs;
      logic [NUM_RD-1:0]        used;
   } rec_t;

   rec_t             r_ex_q, r_ex_d, r_mem_q, r_wb_q;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] stall_events_q, stall_events_d;
   logic             hazard;

   function automatic logic writes(input rec_t r, input logic [REG_AW-1:0] a);
      return r.valid && r.we && (r.rd == a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Operand bypass for the instruction in EX; the newer EX/MEM result beats MEM/WB.
   always_comb begin
      ex_opnd = ex_rf_data;
      fwd_sel = '0;
      if (FWD_EN != 0) begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (r_ex_q.used[i]) begin
               if (writes(r_mem_q, r_ex_q.rs[i*REG_AW +: REG_AW])) begin
                  fwd_sel[i*2 +: 2]      = 2'b10;
                  ex_opnd[i*DATA_W +: DATA_W] = exmem_alu;
               end else if (writes(r_wb_q, r_ex_q.rs[i*REG_AW +: REG_AW])) begin
                  fwd_sel[i*2 +: 2]      = 2'b01;
                  ex_opnd[i*DATA_W +: DATA_W] = memwb_wdata;
               end
            end
         end
      end
   end

   // Without bypass the write-through RF makes a WB producer harmless; EX and MEM must drain.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (id_valid && id_rs_used[i]) begin
            if (FWD_EN != 0) begin
               if (r_ex_q.load && writes(r_ex_q, id_rs[i*REG_AW +: REG_AW])) hazard = 1'b1;
            end else begin
               if (writes(r_ex_q, id_rs[i*REG_AW +: REG_AW]) ||
                   writes(r_mem_q, id_rs[i*REG_AW +: REG_AW])) hazard = 1'b1;
            end
         end
      end
   end

   assign stall  = hazard & ~flush;
   assign bubble = stall | flush;

   always_comb begin
      r_ex_d = '0;
      if (!bubble && id_valid) begin
         r_ex_d.valid = 1'b1;
         r_ex_d.rd    = id_rd;
         r_ex_d.we    = id_we;
         r_ex_d.load  = id_load;
         r_ex_d.rs    = id_rs;
         r_ex_d.used  = id_rs_used;
      end
   end

   always_comb begin
      state_d        = stall ? StStall : StRun;
      stall_cycles_d = stall_cycles_q;
      stall_events_d = stall_events_q;
      if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
      if (stall && (state_q == StRun) && (stall_events_q != '1)) begin
         stall_events_d = stall_events_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_q         <= '0;
         r_mem_q        <= '0;
         r_wb_q         <= '0;
         state_q        <= StRun;
         stall_cycles_q <= '0;
         stall_events_q <= '0;
      end else begin
         r_ex_q         <= r_ex_d;
         r_mem_q        <= r_ex_q;
         r_wb_q         <= r_mem_q;
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         stall_events_q <= stall_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign stall_events = stall_events_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised bench for fwd_hazard_unit: a bypassing instance and a no-bypass instance with
// narrow counters share one stimulus stream and are each checked against a record-history model.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [9:0]  id_rs = '0;
   logic [1:0]  id_rs_used = '0;
   logic [4:0]  id_rd = '0;
   logic        id_we = 1'b0;
   logic        id_load = 1'b0;
   logic [63:0] ex_rf_data = '0;
   logic [31:0] exmem_alu = '0;
   logic [31:0] memwb_wdata = '0;

   logic [63:0] a_opnd, b_opnd;
   logic [3:0]  a_sel, b_sel;
   logic        a_stall, b_stall, a_bubble, b_bubble;
   logic [15:0] a_cyc, a_ev;
   logic [3:0]  b_cyc, b_ev;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.FWD_EN(1), .ZERO_REG(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
      .ex_rf_data(ex_rf_data), .exmem_alu(exmem_alu), .memwb_wdata(memwb_wdata),
      .ex_opnd(a_opnd), .fwd_sel(a_sel), .stall(a_stall), .bubble(a_bubble),
      .stall_cycles(a_cyc), .stall_events(a_ev)
   );

   fwd_hazard_unit #(.FWD_EN(0), .ZERO_REG(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
      .ex_rf_data(ex_rf_data), .exmem_alu(exmem_alu), .memwb_wdata(memwb_wdata),
      .ex_opnd(b_opnd), .fwd_sel(b_sel), .stall(b_stall), .bubble(b_bubble),
      .stall_cycles(b_cyc), .stall_events(b_ev)
   );

   typedef struct {
      bit valid;
      int rd;
      bit we;
      bit load;
      int rs[2];
      bit used[2];
   } rec_t;

   // Instruction history by age: 0 = EX, 1 = MEM, 2 = WB.
   rec_t pa[3], pb[3];
   int   cyc_a, ev_a, cyc_b, ev_b;
   bit   prev_a, prev_b;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rec_t empty_rec();
      rec_t r;
      r.valid = 0; r.rd = 0; r.we = 0; r.load = 0;
      r.rs[0] = 0; r.rs[1] = 0; r.used[0] = 0; r.used[1] = 0;
      return r;
   endfunction

   function automatic bit m_writes(input rec_t r, input int a, input bit zr);
      return r.valid && r.we && (r.rd == a) && !(zr && a == 0);
   endfunction

   task automatic clear_models();
      for (int k = 0; k < 3; k++) begin
         pa[k] = empty_rec();
         pb[k] = empty_rec();
      end
      cyc_a = 0; ev_a = 0; cyc_b = 0; ev_b = 0;
      prev_a = 0; prev_b = 0;
   endtask

   task automatic model_eval(input rec_t ex, input rec_t mem, input rec_t wb, input bit fwd,
                             input bit zr, output logic [3:0] sel, output logic [63:0] opnd,
                             output bit stl);
      sel  = '0;
      opnd = ex_rf_data;
      stl  = 0;
      for (int i = 0; i < 2; i++) begin
         int a;
         a = int'(id_rs[i*5 +: 5]);
         if (fwd && ex.used[i]) begin
            if (m_writes(mem, ex.rs[i], zr)) begin
               sel[i*2 +: 2]   = 2'b10;
               opnd[i*32 +: 32] = exmem_alu;
            end else if (m_writes(wb, ex.rs[i], zr)) begin
               sel[i*2 +: 2]   = 2'b01;
               opnd[i*32 +: 32] = memwb_wdata;
            end
         end
         if (id_valid && id_rs_used[i]) begin
            if (fwd) begin
               if (ex.load && m_writes(ex, a, zr)) stl = 1;
            end else begin
               if (m_writes(ex, a, zr) || m_writes(mem, a, zr)) stl = 1;
            end
         end
      end
      if (flush) stl = 0;
   endtask

   function automatic rec_t issue(input bit bub);
      rec_t r;
      r = empty_rec();
      if (!bub && id_valid) begin
         r.valid = 1; r.rd = int'(id_rd); r.we = id_we; r.load = id_load;
         r.rs[0] = int'(id_rs[4:0]); r.rs[1] = int'(id_rs[9:5]);
         r.used[0] = id_rs_used[0]; r.used[1] = id_rs_used[1];
      end
      return r;
   endfunction

   task automatic check_all(input string ph);
      logic [3:0]  sa, sb;
      logic [63:0] oa, ob;
      bit          ta, tb;
      model_eval(pa[0], pa[1], pa[2], 1'b1, 1'b1, sa, oa, ta);
      model_eval(pb[0], pb[1], pb[2], 1'b0, 1'b0, sb, ob, tb);
      check({ph, "a_sel"},    64'(a_sel),    64'(sa));
      check({ph, "a_opnd"},   a_opnd,        oa);
      check({ph, "a_stall"},  64'(a_stall),  64'(ta));
      check({ph, "a_bubble"}, 64'(a_bubble), 64'(ta | flush));
      check({ph, "a_cyc"},    64'(a_cyc),    64'(cyc_a));
      check({ph, "a_ev"},     64'(a_ev),     64'(ev_a));
      check({ph, "b_sel"},    64'(b_sel),    64'(sb));
      check({ph, "b_opnd"},   b_opnd,        ob);
      check({ph, "b_stall"},  64'(b_stall),  64'(tb));
      check({ph, "b_bubble"}, 64'(b_bubble), 64'(tb | flush));
      check({ph, "b_cyc"},    64'(b_cyc),    64'(cyc_b));
      check({ph, "b_ev"},     64'(b_ev),     64'(ev_b));
   endtask

   // One clock: drive ID fields and random data, check, optionally reset mid-cycle, then advance.
   task automatic cycle(input bit fl, input bit v, input int rs0, input int rs1, input bit u0,
                        input bit u1, input int rd, input bit we, input bit ld,
                        input bit rst_mid);
      logic [3:0]  sa, sb;
      logic [63:0] oa, ob;
      bit          ta, tb;
      flush       = fl;
      id_valid    = v;
      id_rs       = {5'(rs1), 5'(rs0)};
      id_rs_used  = {u1, u0};
      id_rd       = 5'(rd);
      id_we       = we;
      id_load     = ld;
      ex_rf_data  = {$urandom(), $urandom()};
      exmem_alu   = $urandom();
      memwb_wdata = $urandom();
      #2;
      check_all("");
      if (rst_mid) begin
         rst_n = 1'b0;
         clear_models();
         #1;
         check_all("rst_");
      end
      model_eval(pa[0], pa[1], pa[2], 1'b1, 1'b1, sa, oa, ta);
      model_eval(pb[0], pb[1], pb[2], 1'b0, 1'b0, sb, ob, tb);
      @(posedge clk);
      if (rst_n) begin
         pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = issue(ta | fl);
         pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = issue(tb | fl);
         if (ta) cyc_a = (cyc_a < 65535) ? cyc_a + 1 : cyc_a;
         if (ta && !prev_a) ev_a = (ev_a < 65535) ? ev_a + 1 : ev_a;
         if (tb) cyc_b = (cyc_b < 15) ? cyc_b + 1 : cyc_b;
         if (tb && !prev_b) ev_b = (ev_b < 15) ? ev_b + 1 : ev_b;
         prev_a = ta;
         prev_b = tb;
      end
      @(negedge clk);
   endtask

   task automatic nop();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      clear_models();
      @(negedge clk);
      nop();
      rst_n = 1'b1;
      // add r3 then reader of r3 on port 0
      cycle(0, 1, 1, 2, 1, 1, 3, 1, 0, 0);
      cycle(0, 1, 3, 0, 1, 0, 6, 1, 0, 0);
      repeat (3) nop();
      // r5 produced twice, read on port 1: newest producer wins
      cycle(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      cycle(0, 1, 0, 5, 0, 1, 9, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 5, 0, 1, 9, 1, 0, 0);
      repeat (3) nop();
      // lw r4 followed by a reader held in ID while stalled
      cycle(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
      repeat (4) cycle(0, 1, 4, 1, 1, 1, 8, 1, 0, 0);
      repeat (3) nop();
      // writes to r0 never forward or stall on the hard-wired-zero instance
      cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      repeat (3) cycle(0, 1, 0, 0, 1, 1, 2, 1, 0, 0);
      repeat (3) nop();
      // add r7, reader of r7
      cycle(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
      repeat (4) cycle(0, 1, 7, 0, 1, 0, 1, 1, 0, 0);
      repeat (3) nop();
      // load-use coinciding with flush, then reset asserted during a stall
      cycle(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
      cycle(1, 1, 4, 4, 1, 1, 2, 1, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
      cycle(0, 1, 4, 0, 1, 0, 2, 1, 0, 1);
      rst_n = 1'b1;
      nop();
      // Random traffic over a small register range to provoke frequent dependencies.
      for (int n = 0; n < 800; n++) begin
         cycle(($urandom_range(7) == 0), ($urandom_range(7) != 0), $urandom_range(3),
               $urandom_range(3), $urandom_range(1), $urandom_range(1), $urandom_range(3),
               $urandom_range(3) != 0, $urandom_range(2) == 0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
